// File: rtl/puvvada_says_btn_capture.sv
// Button front end: synchronizes, debounces and edge-qualifies U/R/D/L into single-cycle codes.
// Optional macro PUVVADA_BTN_MULTI_ERR_EN adds the multi_err pulse for rejected simultaneous presses.
module puvvada_says_btn_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Btn_U,
    input  logic       Btn_R,
    input  logic       Btn_D,
    input  logic       Btn_L,
    input  logic       Enable,
    output logic       btn_valid,
    output logic [3:0] btn_code,
`ifdef PUVVADA_BTN_MULTI_ERR_EN
    output logic       multi_err,
`endif
    output logic [3:0] last_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    // Bit order: 0=U, 1=R, 2=D, 3=L, so the code is simply bit index + 1.
    logic [3:0] btn_raw;
    logic [3:0] sync;
    assign btn_raw = {Btn_L, Btn_D, Btn_R, Btn_U};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_bit_reg;
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    meta_reg     <= 1'b0;
                    sync_bit_reg <= 1'b0;
                end else begin
                    meta_reg     <= btn_raw[gi];
                    sync_bit_reg <= meta_reg;
                end
            end
            assign sync[gi] = sync_bit_reg;
        end
    endgenerate

    logic [3:0]       cand_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       deb_reg;

    // One shared counter: any change on any button restarts the stability window.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand_reg <= 4'd0;
            cnt_reg  <= '0;
            deb_reg  <= 4'd0;
        end else if (sync != cand_reg) begin
            cand_reg <= sync;
            cnt_reg  <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            deb_reg  <= cand_reg;
        end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
        end
    end

    state_t     state_reg, state_next;
    logic       valid_reg, valid_next;
    logic [3:0] code_reg, code_next;
    logic [3:0] last_reg, last_next;
    logic       one_hot;
    logic [3:0] enc;

    assign one_hot = (deb_reg != 4'd0) && ((deb_reg & (deb_reg - 4'd1)) == 4'd0);

    always_comb begin
        enc = 4'd0;
        case (deb_reg)
            4'b0001: enc = 4'd1;
            4'b0010: enc = 4'd2;
            4'b0100: enc = 4'd3;
            4'b1000: enc = 4'd4;
            default: enc = 4'd0;
        endcase
    end

`ifdef PUVVADA_BTN_MULTI_ERR_EN
    logic multi_reg, multi_next;
`endif

    always_comb begin
        state_next = state_reg;
        valid_next = 1'b0;
        code_next  = 4'd0;
        last_next  = last_reg;
`ifdef PUVVADA_BTN_MULTI_ERR_EN
        multi_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (deb_reg != 4'd0) begin
                    state_next = HELD;
                    if (one_hot) begin
                        if (Enable) begin
                            valid_next = 1'b1;
                            code_next  = enc;
                            last_next  = enc;
                        end
                    end else begin
`ifdef PUVVADA_BTN_MULTI_ERR_EN
                        multi_next = 1'b1;
`endif
                    end
                end
            end
            HELD: begin
                // Nothing fires again until every button has been released.
                if (deb_reg == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            code_reg  <= 4'd0;
            last_reg  <= 4'd0;
`ifdef PUVVADA_BTN_MULTI_ERR_EN
            multi_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            code_reg  <= code_next;
            last_reg  <= last_next;
`ifdef PUVVADA_BTN_MULTI_ERR_EN
            multi_reg <= multi_next;
`endif
        end
    end

    assign btn_valid = valid_reg;
    assign btn_code  = code_reg;
    assign last_code = last_reg;
`ifdef PUVVADA_BTN_MULTI_ERR_EN
    assign multi_err = multi_reg;
`endif

endmodule

// File: tb/tb_puvvada_says_btn_capture.sv
// Bench for puvvada_says_btn_capture with DEBOUNCE_CYCLES=4: vector table plus corner sequences,
// expected pulses queued at drive time and matched by a negedge monitor.
module tb_puvvada_says_btn_capture;

    localparam int DEB = 4;
    localparam int LAT = DEB + 4;   // drive cycle -> observed pulse cycle

    logic       clk = 1'b0;
    logic       rst;
    logic       bu, br, bd, bl, en;
    logic       btn_valid;
    logic [3:0] btn_code;
    logic [3:0] last_code;
`ifdef PUVVADA_BTN_MULTI_ERR_EN
    logic       multi_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] btn;     // {L,D,R,U}
        logic       en;
        int         hold;
        logic [3:0] code;    // 0 = no pulse expected
        logic       multi;
    } vec_t;

    exp_t       exp_q[$];
    int         multi_q[$];
    logic [3:0] exp_last = 4'd0;
    vec_t       vecs[12];

    puvvada_says_btn_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .Btn_U(bu),
        .Btn_R(br),
        .Btn_D(bd),
        .Btn_L(bl),
        .Enable(en),
        .btn_valid(btn_valid),
        .btn_code(btn_code),
`ifdef PUVVADA_BTN_MULTI_ERR_EN
        .multi_err(multi_err),
`endif
        .last_code(last_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        bu = b[0];
        br = b[1];
        bd = b[2];
        bl = b[3];
    endtask

    task automatic expect_pulse(input logic [3:0] code);
        exp_t e;
        e.cyc  = cyc + LAT;
        e.code = code;
        exp_q.push_back(e);
        exp_last = code;
    endtask

    task automatic check_last(input string name);
        checks++;
        if (last_code !== exp_last) begin
            failures++;
            $display("FAIL last_code_%s got=%0d want=%0d", name, last_code, exp_last);
        end
    endtask

    task automatic check_reset_outs(input string name);
        checks++;
        if (btn_valid !== 1'b0 || btn_code !== 4'd0 || last_code !== 4'd0) begin
            failures++;
            $display("FAIL reset_outs_%s got valid=%b code=%0d last=%0d want all 0",
                     name, btn_valid, btn_code, last_code);
        end
`ifdef PUVVADA_BTN_MULTI_ERR_EN
        checks++;
        if (multi_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_multi_%s got=%b want=0", name, multi_err);
        end
`endif
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (cyc > 0) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse got=none want code=%0d at cyc=%0d", e.code, e.cyc);
            end
            checks++;
            if (btn_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse got code=%0d at cyc=%0d want=no pulse", btn_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.code !== btn_code || last_code !== btn_code) begin
                        failures++;
                        $display("FAIL pulse got cyc=%0d code=%0d last=%0d want cyc=%0d code=%0d",
                                 cyc, btn_code, last_code, e.cyc, e.code);
                    end else begin
                        $display("pulse cyc=%0d code=%0d", cyc, btn_code);
                    end
                end
            end else if (btn_code !== 4'd0 || btn_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_code got valid=%b code=%0d want valid=0 code=0", btn_valid, btn_code);
            end
`ifdef PUVVADA_BTN_MULTI_ERR_EN
            if (multi_q.size() != 0 && multi_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_multi got=none want at cyc=%0d", multi_q.pop_front());
            end
            checks++;
            if (multi_err === 1'b1) begin
                if (multi_q.size() == 0 || multi_q[0] != cyc || btn_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL multi_err got pulse at cyc=%0d valid=%b want none", cyc, btn_valid);
                end else begin
                    void'(multi_q.pop_front());
                    $display("multi_err cyc=%0d", cyc);
                end
            end else if (multi_err !== 1'b0) begin
                failures++;
                $display("FAIL multi_err_x got=%b want=0", multi_err);
            end
`endif
        end
    end

    task automatic apply_vec(input vec_t v);
        set_btn(v.btn);
        en = v.en;
        if (v.code != 4'd0) expect_pulse(v.code);
`ifdef PUVVADA_BTN_MULTI_ERR_EN
        if (v.multi) multi_q.push_back(cyc + LAT);
`endif
        repeat (v.hold) tick();
        set_btn(4'b0000);
        en = 1'b1;
        repeat (14) tick();
        check_last(v.name);
        $display("vec %s btn=%b en=%b hold=%0d last=%0d", v.name, v.btn, v.en, v.hold, last_code);
    endtask

    initial begin
        vecs[0]  = '{"press_L",   4'b1000, 1'b1, 20, 4'd4, 1'b0};
        vecs[1]  = '{"press_U",   4'b0001, 1'b1, 20, 4'd1, 1'b0};
        vecs[2]  = '{"press_R",   4'b0010, 1'b1, 20, 4'd2, 1'b0};
        vecs[3]  = '{"press_D",   4'b0100, 1'b1, 20, 4'd3, 1'b0};
        vecs[4]  = '{"D_disabled",4'b0100, 1'b0, 20, 4'd0, 1'b0};
        vecs[5]  = '{"multi_UR",  4'b0011, 1'b1, 20, 4'd0, 1'b1};
        vecs[6]  = '{"multi_RDL", 4'b1110, 1'b0, 20, 4'd0, 1'b1};
        vecs[7]  = '{"glitch_3",  4'b0001, 1'b1, 3,  4'd0, 1'b0};
        vecs[8]  = '{"glitch_4",  4'b1000, 1'b1, 4,  4'd0, 1'b0};
        vecs[9]  = '{"min_hold_5",4'b1000, 1'b1, 5,  4'd4, 1'b0};
        vecs[10] = '{"none",      4'b0000, 1'b1, 10, 4'd0, 1'b0};
        vecs[11] = '{"press_U2",  4'b0001, 1'b1, 8,  4'd1, 1'b0};

        // Reset held with R pressed: outputs stay 0, then a full debounce fires R.
        rst = 1'b1;
        en  = 1'b1;
        set_btn(4'b0010);
        repeat (3) begin
            tick();
            check_reset_outs("init");
        end
        rst = 1'b0;
        expect_pulse(4'd2);
        repeat (15) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        check_last("after_reset");
        $display("seq reset_with_R last=%0d", last_code);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Bounce: 1,0,1,0 then steady 1; one pulse timed from the final rise.
        set_btn(4'b0001); tick();
        set_btn(4'b0000); tick();
        set_btn(4'b0001); tick();
        set_btn(4'b0000); tick();
        set_btn(4'b0001);
        expect_pulse(4'd1);
        repeat (20) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        check_last("bounce");
        $display("seq bounce last=%0d", last_code);

        // Enable rising mid-hold must not fire; a fresh press afterwards does.
        en = 1'b0;
        set_btn(4'b0100);
        repeat (10) tick();
        en = 1'b1;
        repeat (10) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        set_btn(4'b0100);
        expect_pulse(4'd3);
        repeat (15) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        check_last("enable_gate");
        $display("seq enable_gate last=%0d", last_code);

        // Second button while HELD: R fires, adding D and dropping R does nothing.
        set_btn(4'b0010);
        expect_pulse(4'd2);
        repeat (12) tick();
        set_btn(4'b0110);
        repeat (12) tick();
        set_btn(4'b0100);
        repeat (12) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        check_last("held_second");
        $display("seq held_second last=%0d", last_code);

        // Reset mid-press: everything clears, the held button debounces again and fires.
        set_btn(4'b1000);
        expect_pulse(4'd4);
        repeat (12) tick();
        rst = 1'b1;
        exp_last = 4'd0;
        repeat (2) begin
            tick();
            check_reset_outs("mid_press");
        end
        rst = 1'b0;
        expect_pulse(4'd4);
        repeat (12) tick();
        set_btn(4'b0000);
        repeat (14) tick();
        check_last("mid_reset");
        $display("seq mid_reset last=%0d", last_code);

        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses got=%0d want=0", exp_q.size());
        end
        checks++;
        if (multi_q.size() != 0) begin
            failures++;
            $display("FAIL pending_multi got=%0d want=0", multi_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
